// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Registered multi-lane immediate generator for the Register stage.
//            Decodes I/SHAMT/S/U/J/B (and optionally RVC CI/CJ/CB) immediates
//            for LANES instructions per cycle. A two-entry skid buffer keeps
//            in_ready registered, and flush drops all in-flight bundles.
// Options  : define IMM_COMPRESSED_EN to decode codes 8/9/10 as CI/CJ/CB;
//            when it is undefined those codes are reported as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic [32*LANES-1:0]    in_instr,
  input  logic [4*LANES-1:0]     in_imm_src,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_valid,
  output logic [XLEN*LANES-1:0]  out_imm,
  output logic [LANES-1:0]       out_illegal
);

  // Skid buffer occupancy: A holds the presented bundle, B the overflow.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_nxt;

  logic [LANES-1:0]       dec_illegal;
  logic [XLEN*LANES-1:0]  dec_imm;

  logic [LANES-1:0]       b_lane_valid;
  logic [XLEN*LANES-1:0]  b_imm;
  logic [LANES-1:0]       b_illegal;

  logic                   accept;
  logic                   drain;
  logic                   a_from_in;
  logic                   a_from_b;
  logic                   a_clear;
  logic                   b_load;

  // --------------------------------------------------------------------------
  // Per-lane immediate decode
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [31:0]     instr;
      logic [3:0]      src;
      logic [XLEN-1:0] imm;
      logic            illegal;
      logic            unused_bits;

      assign instr = in_instr[32*g +: 32];
      assign src   = in_imm_src[4*g +: 4];

`ifdef IMM_COMPRESSED_EN
      assign unused_bits = &{1'b0, instr[1:0]};
`else
      assign unused_bits = &{1'b0, instr[6:0]};
`endif

      // Select the immediate layout; invalid lanes decode to all zeros.
      always_comb begin
        imm     = '0;
        illegal = 1'b0;
        if (in_lane_valid[g]) begin
          case (src)
            4'd0: imm = XLEN'($signed(instr[31:20]));
            4'd1: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            4'd2: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            4'd3: imm = XLEN'($signed({instr[31:12], 12'b0}));
            4'd4: imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                       instr[30:21], 1'b0}));
            4'd5: imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                       instr[11:8], 1'b0}));
`ifdef IMM_COMPRESSED_EN
            // c.li / c.addi: imm[5|4:0] = instr[12|6:2]
            4'd8: imm = XLEN'($signed({instr[12], instr[6:2]}));
            // c.j: offset[11|4|9:8|10|6|7|3:1|5] = instr[12:2]
            4'd9: imm = XLEN'($signed({instr[12], instr[8], instr[10:9],
                                       instr[6], instr[7], instr[2],
                                       instr[11], instr[5:3], 1'b0}));
            // c.beqz / c.bnez: offset[8|4:3] = instr[12:10],
            // offset[7:6|2:1|5] = instr[6:2]
            4'd10: imm = XLEN'($signed({instr[12], instr[6:5], instr[2],
                                        instr[11:10], instr[4:3], 1'b0}));
`endif
            default: illegal = 1'b1;
          endcase
        end
      end

      assign dec_imm[XLEN*g +: XLEN] = imm;
      assign dec_illegal[g]          = illegal;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Skid buffer control
  // --------------------------------------------------------------------------
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Next occupancy and which entry moves where.
  always_comb begin
    state_nxt = state;
    a_from_in = 1'b0;
    a_from_b  = 1'b0;
    a_clear   = 1'b0;
    b_load    = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          a_from_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          a_from_in = 1'b1;
        end else if (accept) begin
          state_nxt = ST_TWO;
          b_load    = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
          a_clear   = 1'b1;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can occur.
        if (drain) begin
          state_nxt = ST_ONE;
          a_from_b  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_EMPTY;
        a_clear   = 1'b1;
      end
    endcase
  end

  // State, ready and entry registers; reset outranks flush, flush outranks traffic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_EMPTY;
      in_ready       <= 1'b0;
      out_lane_valid <= '0;
      out_imm        <= '0;
      out_illegal    <= '0;
      b_lane_valid   <= '0;
      b_imm          <= '0;
      b_illegal      <= '0;
    end else if (flush) begin
      state          <= ST_EMPTY;
      in_ready       <= 1'b1;
      out_lane_valid <= '0;
      out_imm        <= '0;
      out_illegal    <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
      if (a_from_in) begin
        out_lane_valid <= in_lane_valid;
        out_imm        <= dec_imm;
        out_illegal    <= dec_illegal;
      end else if (a_from_b) begin
        out_lane_valid <= b_lane_valid;
        out_imm        <= b_imm;
        out_illegal    <= b_illegal;
      end else if (a_clear) begin
        out_lane_valid <= '0;
        out_imm        <= '0;
        out_illegal    <= '0;
      end
      if (b_load) begin
        b_lane_valid <= in_lane_valid;
        b_imm        <= dec_imm;
        b_illegal    <= dec_illegal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Scoreboard bench for imm_extend_pipe (XLEN=32/LANES=2 main
//            instance plus an XLEN=64/LANES=1 instance for wide formats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

  typedef struct packed {
    logic [1:0]  lv;
    logic [63:0] imm;
    logic [1:0]  ill;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_lane_valid;
  logic [63:0] in_instr;
  logic [7:0]  in_imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane_valid;
  logic [63:0] out_imm;
  logic [1:0]  out_illegal;

  logic        b_flush;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [0:0]  b_in_lane_valid;
  logic [31:0] b_in_instr;
  logic [3:0]  b_in_imm_src;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [0:0]  b_out_lane_valid;
  logic [63:0] b_out_imm;
  logic [0:0]  b_out_illegal;

  int   total = 0;
  int   bad   = 0;
  int   acc_cnt = 0;
  exp_t q[$];

  logic [63:0] snap_imm;
  logic [1:0]  snap_lv;
  logic [1:0]  snap_ill;
  int          base;

`ifdef IMM_COMPRESSED_EN
  localparam logic [63:0] EXP_CI_IMM = 64'h0000_0000_FFFF_FFFF;
  localparam logic [1:0]  EXP_CI_ILL = 2'b10;
`else
  localparam logic [63:0] EXP_CI_IMM = 64'h0;
  localparam logic [1:0]  EXP_CI_ILL = 2'b11;
`endif

  imm_extend_pipe #(.XLEN(32), .LANES(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_instr(in_instr), .in_imm_src(in_imm_src),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_valid(out_lane_valid), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  imm_extend_pipe #(.XLEN(64), .LANES(1)) dut64 (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_lane_valid(b_in_lane_valid), .in_instr(b_in_instr), .in_imm_src(b_in_imm_src),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_lane_valid(b_out_lane_valid), .out_imm(b_out_imm), .out_illegal(b_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sign-extend the low n bits of t to 64 bits.
  function automatic logic [63:0] sx(input logic [63:0] t, input int n);
    longint s;
    s = longint'(t << (64 - n));
    s = s >>> (64 - n);
    return s;
  endfunction

  // Reference immediate: {illegal, imm masked to xlen}.
  function automatic logic [64:0] model(input logic [31:0] i, input logic [3:0] c, input int xlen);
    logic [63:0] t;
    logic [63:0] v;
    logic        ill;
    t = '0; v = '0; ill = 1'b0;
    case (c)
      4'd0: v = sx({52'b0, i[31:20]}, 12);
      4'd1: v = (xlen == 64) ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
      4'd2: v = sx({52'b0, i[31:25], i[11:7]}, 12);
      4'd3: v = sx({32'b0, i[31:12], 12'b0}, 32);
      4'd4: begin
        t[20] = i[31]; t[10:1] = i[30:21]; t[11] = i[20]; t[19:12] = i[19:12];
        v = sx(t, 21);
      end
      4'd5: begin
        t[12] = i[31]; t[11] = i[7]; t[10:5] = i[30:25]; t[4:1] = i[11:8];
        v = sx(t, 13);
      end
`ifdef IMM_COMPRESSED_EN
      4'd8: begin
        t[5] = i[12]; t[4:0] = i[6:2];
        v = sx(t, 6);
      end
      4'd9: begin
        t[11] = i[12]; t[4] = i[11]; t[9:8] = i[10:9]; t[10] = i[8];
        t[6] = i[7]; t[7] = i[6]; t[3:1] = i[5:3]; t[5] = i[2];
        v = sx(t, 12);
      end
      4'd10: begin
        t[8] = i[12]; t[4:3] = i[11:10]; t[7:6] = i[6:5]; t[2:1] = i[4:3]; t[5] = i[2];
        v = sx(t, 9);
      end
`endif
      default: ill = 1'b1;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {ill, v};
  endfunction

  function automatic exp_t make_exp(input logic [1:0] lv, input logic [63:0] ins, input logic [7:0] src);
    exp_t        e;
    logic [64:0] r;
    e = '0;
    e.lv = lv;
    for (int l = 0; l < 2; l++) begin
      r = model(ins[32*l +: 32], src[4*l +: 4], 32);
      if (lv[l]) begin
        e.imm[32*l +: 32] = r[31:0];
        e.ill[l]          = r[64];
      end
    end
    return e;
  endfunction

  // Scoreboard: sampled mid-cycle, so these are the values the next edge sees.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("sb_unexpected", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("sb_lane_valid", {62'b0, out_lane_valid}, {62'b0, e.lv});
          check("sb_imm", out_imm, e.imm);
          check("sb_illegal", {62'b0, out_illegal}, {62'b0, e.ill});
        end
      end
      if (in_valid && in_ready) acc_cnt++;
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(make_exp(in_lane_valid, in_instr, in_imm_src));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [1:0] lv, input logic [31:0] i0, input logic [3:0] c0,
                            input logic [31:0] i1, input logic [3:0] c1);
    in_lane_valid = lv;
    in_instr      = {i1, i0};
    in_imm_src    = {c1, c0};
  endtask

  task automatic wide_one(input string tag, input logic [31:0] ins, input logic [3:0] c,
                          input logic [63:0] exp_imm, input logic exp_ill);
    b_in_valid = 1'b1; b_in_lane_valid = 1'b1; b_in_instr = ins; b_in_imm_src = c;
    tick;
    b_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, {63'b0, b_out_valid}, 64'd1);
    check({tag, "_imm"}, b_out_imm, exp_imm);
    check({tag, "_ill"}, {63'b0, b_out_illegal}, {63'b0, exp_ill});
    check({tag, "_lv"}, {63'b0, b_out_lane_valid}, 64'd1);
    tick;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_bundle(2'b00, 32'h0, 4'd0, 32'h0, 4'd0);
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_in_lane_valid = 1'b0; b_in_instr = '0; b_in_imm_src = '0;

    // Reset state
    repeat (3) tick;
    @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_out_lv", {62'b0, out_lane_valid}, 64'd0);
    check("rst_out_ill", {62'b0, out_illegal}, 64'd0);
    tick;
    reset = 1'b1;
    tick;
    @(negedge clk);
    check("rel_in_ready", {63'b0, in_ready}, 64'd1);
    check("rel_b_in_ready", {63'b0, b_in_ready}, 64'd1);
    tick;

    // XLEN=64 formats
    wide_one("w_u", 32'h800000B7, 4'd3, 64'hFFFF_FFFF_8000_0000, 1'b0);
    wide_one("w_shamt", 32'h03F09093, 4'd1, 64'h0000_0000_0000_003F, 1'b0);
    wide_one("w_b", 32'hFE000EE3, 4'd5, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    wide_one("w_i", 32'hFFF00093, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wide_one("w_bad", 32'hFFFFFFFF, 4'd7, 64'h0, 1'b1);

    // Latency: I on lane 0, B on lane 1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_bundle(2'b11, 32'hFFF00093, 4'd0, 32'hFE000EE3, 4'd5);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", {63'b0, out_valid}, 64'd1);
    check("lat_imm", out_imm, 64'hFFFF_FFFC_FFFF_FFFF);
    tick;

    // Back-to-back stream of format vectors
    in_valid = 1'b1;
    set_bundle(2'b11, 32'h800000B7, 4'd3, 32'h03F09093, 4'd1);  tick;
    set_bundle(2'b11, 32'hFE112E23, 4'd2, 32'h8000006F, 4'd4);  tick;
    set_bundle(2'b11, 32'h7FF0006F, 4'd4, 32'h00008063, 4'd5);  tick;
    set_bundle(2'b01, 32'h12345093, 4'd0, 32'hFFFFFFFF, 4'd7);  tick;
    set_bundle(2'b10, 32'hFFFFFFFF, 4'd0, 32'h0000B7FD, 4'd9);  tick;
    set_bundle(2'b11, 32'h0000D0FD, 4'd10, 32'h0000AFFD, 4'd9); tick;
    in_valid = 1'b0;
    @(negedge clk);
    check("tput_accepts", 64'(acc_cnt), 64'd7);
    tick;
    tick;

    // CI on lane 0, unsupported code on lane 1
    in_valid = 1'b1;
    set_bundle(2'b11, 32'h000050FD, 4'd8, 32'h000050FD, 4'd7);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    check("ci_imm", out_imm, EXP_CI_IMM);
    check("ci_ill", {62'b0, out_illegal}, {62'b0, EXP_CI_ILL});
    check("ci_lv", {62'b0, out_lane_valid}, 64'd3);
    tick;
    tick;

    // Stall: three cycles of in_valid with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    base = acc_cnt;
    set_bundle(2'b11, 32'h00100093, 4'd0, 32'h00200093, 4'd0);
    tick;
    set_bundle(2'b11, 32'h00300093, 4'd0, 32'h00400093, 4'd0);
    @(negedge clk);
    snap_imm = out_imm; snap_lv = out_lane_valid; snap_ill = out_illegal;
    tick;
    set_bundle(2'b11, 32'h00500093, 4'd0, 32'h00600093, 4'd0);
    @(negedge clk);
    check("stall_ready", {63'b0, in_ready}, 64'd0);
    check("stall_imm1", out_imm, snap_imm);
    tick;
    @(negedge clk);
    check("stall_imm2", out_imm, snap_imm);
    check("stall_lv", {62'b0, out_lane_valid}, {62'b0, snap_lv});
    check("stall_ill", {62'b0, out_illegal}, {62'b0, snap_ill});
    check("stall_valid", {63'b0, out_valid}, 64'd1);
    check("stall_accepts", 64'(acc_cnt - base), 64'd2);
    in_valid  = 1'b0;
    tick;
    out_ready = 1'b1;
    repeat (3) tick;

    // Flush while full, then flush coinciding with an accept
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_bundle(2'b11, 32'h00700093, 4'd0, 32'h00800093, 4'd0); tick;
    set_bundle(2'b11, 32'h00900093, 4'd0, 32'h00A00093, 4'd0); tick;
    set_bundle(2'b11, 32'h00B00093, 4'd0, 32'h00C00093, 4'd0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", {63'b0, out_valid}, 64'd0);
    check("flush_ready", {63'b0, in_ready}, 64'd1);
    tick;
    in_valid = 1'b1;
    flush    = 1'b1;
    set_bundle(2'b11, 32'h00D00093, 4'd0, 32'h00E00093, 4'd0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_acc_valid", {63'b0, out_valid}, 64'd0);
    out_ready = 1'b1;
    repeat (4) tick;

    // Reset during a stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_bundle(2'b11, 32'h00F00093, 4'd0, 32'h01000093, 4'd0); tick;
    set_bundle(2'b11, 32'h01100093, 4'd0, 32'h01200093, 4'd0); tick;
    reset = 1'b0;
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    check("mrst_valid", {63'b0, out_valid}, 64'd0);
    check("mrst_ready", {63'b0, in_ready}, 64'd0);
    check("mrst_imm", out_imm, 64'd0);
    check("mrst_lv", {62'b0, out_lane_valid}, 64'd0);
    check("mrst_ill", {62'b0, out_illegal}, 64'd0);
    reset = 1'b1;
    tick;
    @(negedge clk);
    check("mrst_rel_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (3) tick;

    // Random traffic with random backpressure and occasional flush
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      set_bundle(2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom, 4'($urandom_range(0, 15)));
      tick;
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) tick;
    check("sb_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
